// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the registered immediate extension unit:
// extension mode codes, occupancy state encoding and default widths.
package imm_extend_pipe_pkg;

  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;
  localparam logic [1:0] EXT_BOFF  = 2'b11;

  localparam int DEF_IN_W  = 16;
  localparam int DEF_OUT_W = 32;
  localparam int DEF_TAG_W = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/imm_extend_pipe_core.sv
// Combinational immediate extender (sign / zero / upper / branch offset).
// Shared with the load-data path for byte and halfword extension.
module imm_extend_core
  import imm_extend_pipe_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic [OUT_W-1:0] ext_data
);

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] upper_ext;
  logic [OUT_W-1:0] boff_ext;

  assign sign_ext  = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign zero_ext  = {{(OUT_W-IN_W){1'b0}}, in_data};
  assign upper_ext = {in_data, {(OUT_W-IN_W){1'b0}}};
  // Word-aligned branch offset: the top two sign bits fall off the end.
  assign boff_ext  = {sign_ext[OUT_W-3:0], 2'b00};

  always_comb begin
    // NOTE: assign a default before the case so no path leaves ext_data unassigned (no latch).
    ext_data = sign_ext;
    case (in_mode)
      EXT_SIGN:  ext_data = sign_ext;
      EXT_ZERO:  ext_data = zero_ext;
      EXT_UPPER: ext_data = upper_ext;
      EXT_BOFF:  ext_data = boff_ext;
      default:   ext_data = sign_ext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extension stage with valid/ready handshake, 2-entry
// skid buffer, flush and tag sideband. Optional counters: IMM_EXT_PERF_EN.
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      perf_xfer,
  output logic [31:0]      perf_stall
);

  if (OUT_W < IN_W + 2) begin : g_width_check
    $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
  end

  occ_e             state;
  occ_e             state_nx;
  logic [OUT_W-1:0] ext_data;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic             accept;
  logic             drain;
  logic             load_out;
  logic             load_skid;
  logic             out_from_skid;

  imm_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_data  (in_data),
    .in_mode  (in_mode),
    .ext_data (ext_data)
  );

  // Both handshake outputs decode the state register only, so out_ready
  // never reaches in_ready combinationally.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_nx      = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nx = ONE;
            load_out = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_out = 1'b1;
          end else if (accept) begin
            state_nx  = TWO;
            load_skid = 1'b1;
          end else if (drain) begin
            state_nx = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            state_nx      = ONE;
            load_out      = 1'b1;
            out_from_skid = 1'b1;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: the data registers are reset too; out_data and skid contents must read 0 after reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      out_data  <= '0;
      out_tag   <= '0;
      skid_data <= '0;
      skid_tag  <= '0;
    end else begin
      if (load_out) begin
        out_data <= out_from_skid ? skid_data : ext_data;
        out_tag  <= out_from_skid ? skid_tag  : in_tag;
      end
      if (load_skid) begin
        skid_data <= ext_data;
        skid_tag  <= in_tag;
      end
    end
  end

`ifdef IMM_EXT_PERF_EN
  logic [31:0] xfer_cnt;
  logic [31:0] stall_cnt;

  // Counters observe raw handshakes and deliberately ignore flush.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (drain) begin
        xfer_cnt <= xfer_cnt + 32'd1;
      end
      if (in_valid && !in_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign perf_xfer  = xfer_cnt;
  assign perf_stall = stall_cnt;
`else
  assign perf_xfer  = 32'd0;
  assign perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic [31:0] perf_xfer;
  logic [31:0] perf_stall;

  imm_extend_pipe dut (
    .Clk        (clk),
    .Reset      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .perf_xfer  (perf_xfer),
    .perf_stall (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } entry_t;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  mode;
    logic [31:0] expected;
  } vec_t;

  entry_t      exp_q[$];
  int unsigned exp_xfer;
  int unsigned exp_stall;
  int          tests;
  int          failed;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference extension from the arithmetic definitions of each mode.
  function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m);
    int sv;
    sv = int'($signed(d));
    case (m)
      2'd0:    return 32'(sv);
      2'd1:    return 32'(d);
      2'd2:    return 32'(d) * 32'd65536;
      default: return 32'(sv * 4);
    endcase
  endfunction

  task automatic drive(input logic v, input logic [15:0] d, input logic [1:0] m,
                       input logic [4:0] t, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    in_tag    = t;
    out_ready = r;
    flush     = f;
  endtask

  // One clock: update the queue model from pre-edge inputs, then compare.
  task automatic tick();
    int     sz;
    bit     acc;
    bit     drn;
    entry_t e;
    sz  = exp_q.size();
    drn = (sz > 0) && out_ready;
    acc = in_valid && (sz < 2);
    e.data = ref_ext(in_data, in_mode);
    e.tag  = in_tag;
    if (!rst_n) begin
      exp_q.delete();
      exp_xfer  = 0;
      exp_stall = 0;
    end else begin
      if (drn) exp_xfer++;
      if (in_valid && sz == 2) exp_stall++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (drn) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    if (exp_q.size() > 0) begin
      check("out_data", 64'(out_data), 64'(exp_q[0].data));
      check("out_tag", 64'(out_tag), 64'(exp_q[0].tag));
    end
`ifdef IMM_EXT_PERF_EN
    check("perf_xfer", 64'(perf_xfer), 64'(exp_xfer));
    check("perf_stall", 64'(perf_stall), 64'(exp_stall));
`else
    check("perf_xfer_tied", 64'(perf_xfer), 64'd0);
    check("perf_stall_tied", 64'(perf_stall), 64'd0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 2'd0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  vec_t        vecs[10];
  logic [31:0] held;
  logic [4:0]  seen_tags[$];

  initial begin
    tests     = 0;
    failed    = 0;
    exp_xfer  = 0;
    exp_stall = 0;
    rst_n     = 1'b0;
    drive(1'b0, 16'h0, 2'd0, 5'd0, 1'b0, 1'b0);

    vecs[0] = '{16'h8001, 2'd0, 32'hFFFF8001};
    vecs[1] = '{16'h8001, 2'd1, 32'h00008001};
    vecs[2] = '{16'h8001, 2'd2, 32'h80010000};
    vecs[3] = '{16'h8001, 2'd3, 32'hFFFE0004};
    vecs[4] = '{16'h7FFF, 2'd0, 32'h00007FFF};
    vecs[5] = '{16'hFFFF, 2'd1, 32'h0000FFFF};
    vecs[6] = '{16'hFFFF, 2'd2, 32'hFFFF0000};
    vecs[7] = '{16'h4000, 2'd3, 32'h00010000};
    vecs[8] = '{16'hC000, 2'd3, 32'hFFFF0000};
    vecs[9] = '{16'h0000, 2'd0, 32'h00000000};

    // Reset state
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);

    // Mode sweep with the consumer always ready
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].data, vecs[i].mode, 5'(i), 1'b1, 1'b0);
      tick();
      check("sweep_data", 64'(out_data), 64'(vecs[i].expected));
    end
    drive(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);
    tick();

    // Backpressure: tags 1,2,3 with out_ready low
    do_reset();
    drive(1'b1, 16'h0011, 2'd0, 5'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0022, 2'd0, 5'd2, 1'b0, 1'b0);
    tick();
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    drive(1'b1, 16'h0033, 2'd0, 5'd3, 1'b0, 1'b0);
    held = out_data;
    for (int i = 0; i < 3; i++) tick();
    check("bp_stable", 64'(out_data), 64'(held));
    out_ready = 1'b1;
    seen_tags.delete();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) drive(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);
      seen_tags.push_back(out_tag);
      tick();
    end
    for (int i = 0; i < 3; i++) check("bp_order", 64'(seen_tags[i]), 64'(i + 1));
`ifdef IMM_EXT_PERF_EN
    check("bp_perf_xfer", 64'(perf_xfer), 64'd3);
    check("bp_perf_stall", 64'(perf_stall), 64'd4);
`else
    check("bp_perf_xfer_off", 64'(perf_xfer), 64'd0);
    check("bp_perf_stall_off", 64'(perf_stall), 64'd0);
`endif

    // Streaming 0x0001..0x0010 SIGN without bubbles
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 16'(i), 2'd0, 5'(i), 1'b1, 1'b0);
      tick();
      check("stream_ready", 64'(in_ready), 64'd1);
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data", 64'(out_data), 64'(i));
    end
    drive(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);
    tick();

    // Flush while in TWO with a concurrent input
    drive(1'b1, 16'h0AAA, 2'd0, 5'd4, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0BBB, 2'd1, 5'd5, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h1234, 2'd0, 5'd9, 1'b0, 1'b1);
    tick();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 16'h7FFF, 2'd1, 5'd6, 1'b0, 1'b0);
    tick();
    check("post_flush_data", 64'(out_data), 64'h00007FFF);
    check("post_flush_tag", 64'(out_tag), 64'd6);
    drive(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);
    tick();

    // Reset mid-stream while in TWO, held low with in_valid asserted
    drive(1'b1, 16'h5555, 2'd2, 5'd7, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h6666, 2'd3, 5'd8, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 16'h7777, 2'd0, 5'd10, 1'b1, 1'b0);
    tick();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    tick();
    tick();
    check("rst_hold_no_accept", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    drive(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom),
            5'($urandom), 1'($urandom), 1'($urandom_range(0, 19) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Registered, parametrised immediate/offset extension unit sitting between ID and the ID/EX pipeline register of the pipelined datapath.
- Replaces the purely combinational 16-to-32 sign extender.
- Adds selectable extension modes (sign, zero, LUI-upper, branch-offset), a valid/ready handshake with a 2-entry skid buffer, flush support and an ID tag carried alongside the data.

Parameters:
- IN_W, 16: immediate input width.
- OUT_W, 32: extended output width; must satisfy OUT_W >= IN_W+2, otherwise an elaboration-time error is raised.
- TAG_W, 5: width of the sideband tag (e.g. destination register).

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-low reset.
- flush  input  1  drop all buffered entries (branch taken / hazard squash).
- in_valid  input  1  producer has an immediate.
- in_ready  output  1  unit can accept; driven from a register only (no combinational path from out_ready).
- in_data  input  IN_W  raw immediate field.
- in_mode  input  2  extension mode: 00 SIGN, 01 ZERO, 10 UPPER, 11 BOFF.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  out_data/out_tag hold a valid result.
- out_ready  input  1  consumer accepts this cycle.
- out_data  output  OUT_W  extended value.
- out_tag  output  TAG_W  tag of out_data.
- perf_xfer  output  32  accepted-output counter (see Optional Feature).
- perf_stall  output  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Arithmetic, applied at input acceptance:
  - SIGN: replicate in_data[IN_W-1] into bits [OUT_W-1:IN_W].
  - ZERO: zero-fill the upper bits.
  - UPPER: in_data placed in [OUT_W-1:OUT_W-IN_W], low bits 0.
  - BOFF: SIGN result shifted left by 2; bits shifted out are discarded, low 2 bits are 0.
- Handshake:
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - out_data/out_tag must stay stable while out_valid && !out_ready.
- Latency: 1 cycle. A value accepted at edge N is visible on out_data after edge N when the output register is empty.
- State machine (occupancy):
  - EMPTY: out_valid=0, in_ready=1.
    - Accept -> ONE.
  - ONE: out_valid=1, in_ready=1.
    - Accept without drain -> TWO; the new entry goes to the skid register.
    - Accept with drain -> ONE; the new entry goes directly to the output register.
    - Drain only -> EMPTY.
  - TWO: out_valid=1, in_ready=0.
    - Drain -> ONE; the skid entry moves to the output register in the same edge.
    - No accept is possible in TWO.
- Ordering is strict FIFO; entries are never reordered or duplicated.
- flush: highest priority after Reset.
  - Next state is EMPTY, out_valid=0, in_ready=1.
  - A concurrent input or output transfer is ignored: the input is dropped; the output is still considered consumed if out_ready was high.
- Reset (Reset==0 at an edge, including mid-operation):
  - State EMPTY, out_valid=0, in_ready=1.
  - out_data=0, out_tag=0, skid contents=0.
  - perf counters=0.
- in_mode and in_tag are sampled only on the accepting edge.
- Data registers do not change in EMPTY when in_valid=0.

Optional Feature:
- Macro: IMM_EXT_PERF_EN.
- When defined:
  - perf_xfer increments on every output transfer.
  - perf_stall increments on every cycle with in_valid && !in_ready.
  - Both counters wrap at 2^32, are cleared by Reset and are not affected by flush.
- When undefined:
  - No counter flops are built.
  - perf_xfer and perf_stall are tied to 0.
  - The port list is unchanged.

Decomposition:
- Shared package holds:
  - mode localparams: EXT_SIGN=2'b00, EXT_ZERO=2'b01, EXT_UPPER=2'b10, EXT_BOFF=2'b11;
  - occupancy state encoding: EMPTY/ONE/TWO;
  - default widths IN_W/OUT_W.
- One natural sub-module: imm_extend_core.
  - Purely combinational: in_data, in_mode -> extended word.
  - Reused by the load-data path for lb/lh extension.
  - imm_extend_pipe wraps it with the skid/handshake logic.

Test Plan:
- Mode sweep, out_ready=1, defaults:
  - in_data=16'h8001 SIGN -> 32'hFFFF8001; ZERO -> 32'h00008001; UPPER -> 32'h80010000; BOFF -> 32'hFFFE0004.
  - Each appears one cycle after acceptance.
- Backpressure:
  - Hold out_ready=0 and send tags 1, 2, 3.
  - Tags 1 and 2 are accepted; in_ready drops to 0 after the second; tag 3 is held.
  - Raise out_ready: outputs appear in order 1, 2, 3; out_data is stable while stalled.
- Simultaneous accept and drain in ONE with continuous streaming of 0x0001..0x0010 SIGN: 16 outputs on 16 consecutive cycles, no bubbles, in_ready constantly 1.
- Flush in TWO with concurrent in_valid=1:
  - Next cycle out_valid=0, in_ready=1, and the flushed input never appears.
  - The next accepted value 16'h7FFF ZERO -> 32'h00007FFF.
- Reset mid-stream:
  - Reset=0 for one edge while in TWO -> out_valid=0, out_data=0, in_ready=1.
  - Reset is held low while in_valid=1: nothing is accepted.
- With IMM_EXT_PERF_EN, run the backpressure scenario: perf_xfer=3 and perf_stall equals the number of cycles tag 3 waited. Without the macro, both counters read 0.
